// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (800x600@72), output flag bundle and width helpers
// used by the timing generator and its axis counters.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 800;
    localparam int VGA_H_FP      = 56;
    localparam int VGA_H_SYNC    = 120;
    localparam int VGA_H_BP      = 64;
    localparam int VGA_V_VISIBLE = 600;
    localparam int VGA_V_FP      = 37;
    localparam int VGA_V_SYNC    = 6;
    localparam int VGA_V_BP      = 23;
    localparam int VGA_H_POL     = 0;
    localparam int VGA_V_POL     = 0;
    localparam int VGA_PIX_DIV   = 1;
    localparam int VGA_PREFETCH  = 16;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic newline;
        logic frame;
        logic vblank;
        logic fetch;
    } vga_flags_t;

    // Bit width able to hold 0..n-1, never narrower than one bit.
    function automatic int vga_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic vga_flags_t vga_idle(input logic h_act, input logic v_act);
        vga_flags_t f;
        f       = '0;
        f.hsync = ~h_act;
        f.vsync = ~v_act;
        f.blank = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: position counter with wrap, plus sync-window and visible-area
// decodes of the current count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int  VISIBLE = VGA_H_VISIBLE,
    parameter int  FP      = VGA_H_FP,
    parameter int  SYNC    = VGA_H_SYNC,
    parameter int  BP      = VGA_H_BP,
    localparam int TOTAL   = VISIBLE + FP + SYNC + BP,
    localparam int W       = vga_w(TOTAL)
) (
    input  logic         clk50,
    input  logic         rst,
    input  logic         clr,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         sync_act,
    output logic         visible
);

    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    assign wrap     = (int'(cnt) == TOTAL - 1);
    assign sync_act = (int'(cnt) >= VISIBLE + FP) && (int'(cnt) < VISIBLE + FP + SYNC);
    assign visible  = (int'(cnt) < VISIBLE);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, H/V axis counters and a registered
// decode stage producing mutually aligned sync, blank, position and pulse outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int  H_VISIBLE = VGA_H_VISIBLE,
    parameter int  H_FP      = VGA_H_FP,
    parameter int  H_SYNC    = VGA_H_SYNC,
    parameter int  H_BP      = VGA_H_BP,
    parameter int  V_VISIBLE = VGA_V_VISIBLE,
    parameter int  V_FP      = VGA_V_FP,
    parameter int  V_SYNC    = VGA_V_SYNC,
    parameter int  V_BP      = VGA_V_BP,
    parameter int  H_POL     = VGA_H_POL,
    parameter int  V_POL     = VGA_V_POL,
    parameter int  PIX_DIV   = VGA_PIX_DIV,
    parameter int  PREFETCH  = VGA_PREFETCH,
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP,
    localparam int HW        = vga_w(H_TOTAL),
    localparam int VW        = vga_w(V_TOTAL),
    localparam int FW        = vga_w(V_VISIBLE)
) (
    input  logic          clk50,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          blank_out,
    output logic [HW-1:0] x_out,
    output logic [VW-1:0] y_out,
    output logic          newline_out,
    output logic          frame_out,
    output logic          vblank_irq,
    output logic          fetch_req,
    output logic [FW-1:0] fetch_line
);

    localparam int   DW    = vga_w(PIX_DIV);
    localparam logic H_ACT = (H_POL != 0);
    localparam logic V_ACT = (V_POL != 0);

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_wrap, h_sync_act, h_vis;
    logic          v_wrap, v_sync_act, v_vis;
    logic [VW-1:0] next_v;
    logic          fetch_hit;

    vga_flags_t    flags_p0, flags_p1;
    logic [HW-1:0] x_p0, x_p1;
    logic [VW-1:0] y_p0, y_p1;
    logic [FW-1:0] fl_p0, fl_p1;
    logic          vld_p1;

    // Stage p0: pixel-tick divider and axis counters
    assign tick = en && (div_cnt == DW'(PIX_DIV - 1));

    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (!en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP)
    ) u_h (
        .clk50    (clk50),
        .rst      (rst),
        .clr      (!en),
        .adv      (tick),
        .cnt      (hcnt),
        .wrap     (h_wrap),
        .sync_act (h_sync_act),
        .visible  (h_vis)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP)
    ) u_v (
        .clk50    (clk50),
        .rst      (rst),
        .clr      (!en),
        .adv      (tick && h_wrap),
        .cnt      (vcnt),
        .wrap     (v_wrap),
        .sync_act (v_sync_act),
        .visible  (v_vis)
    );

    // The line being prefetched is the one after the current line, wrapping at frame end.
    assign next_v    = v_wrap ? '0 : vcnt + 1'b1;
    assign fetch_hit = (int'(hcnt) == H_TOTAL - PREFETCH) && (int'(next_v) < V_VISIBLE);

    always_comb begin
        flags_p0 = vga_idle(H_ACT, V_ACT);
        x_p0     = '0;
        y_p0     = '0;
        fl_p0    = '0;
        if (en) begin
            flags_p0.hsync   = h_sync_act ? H_ACT : ~H_ACT;
            flags_p0.vsync   = v_sync_act ? V_ACT : ~V_ACT;
            flags_p0.blank   = !(h_vis && v_vis);
            flags_p0.newline = (hcnt == '0);
            flags_p0.frame   = (hcnt == '0) && (vcnt == '0);
            flags_p0.vblank  = (hcnt == '0) && (int'(vcnt) == V_VISIBLE);
            flags_p0.fetch   = fetch_hit;
            x_p0             = hcnt;
            y_p0             = vcnt;
            fl_p0            = fetch_hit ? FW'(next_v) : '0;
        end
    end

    // Stage p1: decodes held for a whole pixel period, cleared at once when en drops
    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            flags_p1 <= vga_idle(H_ACT, V_ACT);
            x_p1     <= '0;
            y_p1     <= '0;
            fl_p1    <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= tick;
            if (!en || tick) begin
                flags_p1 <= flags_p0;
                x_p1     <= x_p0;
                y_p1     <= y_p0;
                fl_p1    <= fl_p0;
            end
        end
    end

    assign pix_ce      = vld_p1;
    assign hsync_out   = flags_p1.hsync;
    assign vsync_out   = flags_p1.vsync;
    assign blank_out   = flags_p1.blank;
    assign newline_out = flags_p1.newline;
    assign frame_out   = flags_p1.frame;
    assign vblank_irq  = flags_p1.vblank;
    assign fetch_req   = flags_p1.fetch;
    assign x_out       = x_p1;
    assign y_out       = y_p1;
    assign fetch_line  = fl_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: four parameterisations checked every cycle
// against an arithmetic reference model, a hand-computed vector table and corner sequences.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        pce, hsy, vsy, bl, nl, fr, vb, fq;
        logic [15:0] x, y, fl;
    } obs_t;

    typedef struct {
        int hvis, hfp, hsw, hbp, vvis, vfp, vsw, vbp, hpol, vpol, div, pf;
    } cfg_t;

    typedef struct {
        int   n;
        int   x, y;
        logic bl, hsy, vsy, nl, fr, vb, fq;
        int   fl;
        logic pce;
    } vec_t;

    logic clk, rst;
    logic en_a, en_b, en_c, en_d;

    logic pce_a, hs_a, vs_a, bl_a, nl_a, fr_a, vb_a, fq_a;
    logic [10:0] x_a;
    logic [9:0]  y_a, fl_a;
    logic pce_b, hs_b, vs_b, bl_b, nl_b, fr_b, vb_b, fq_b;
    logic [3:0]  x_b;
    logic [2:0]  y_b;
    logic [1:0]  fl_b;
    logic pce_c, hs_c, vs_c, bl_c, nl_c, fr_c, vb_c, fq_c;
    logic [10:0] x_c;
    logic [9:0]  y_c, fl_c;
    logic pce_d, hs_d, vs_d, bl_d, nl_d, fr_d, vb_d, fq_d;
    logic [3:0]  x_d;
    logic [2:0]  y_d;
    logic [1:0]  fl_d;

    obs_t o_a, o_b, o_c, o_d;
    assign o_a = {pce_a, hs_a, vs_a, bl_a, nl_a, fr_a, vb_a, fq_a, 16'(x_a), 16'(y_a), 16'(fl_a)};
    assign o_b = {pce_b, hs_b, vs_b, bl_b, nl_b, fr_b, vb_b, fq_b, 16'(x_b), 16'(y_b), 16'(fl_b)};
    assign o_c = {pce_c, hs_c, vs_c, bl_c, nl_c, fr_c, vb_c, fq_c, 16'(x_c), 16'(y_c), 16'(fl_c)};
    assign o_d = {pce_d, hs_d, vs_d, bl_d, nl_d, fr_d, vb_d, fq_d, 16'(x_d), 16'(y_d), 16'(fl_d)};

    int   total = 0;
    int   bad   = 0;
    int   n[4];
    cfg_t cfg[4];
    vec_t tbl[18];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk50(clk), .rst(rst), .en(en_a), .pix_ce(pce_a), .hsync_out(hs_a), .vsync_out(vs_a),
        .blank_out(bl_a), .x_out(x_a), .y_out(y_a), .newline_out(nl_a), .frame_out(fr_a),
        .vblank_irq(vb_a), .fetch_req(fq_a), .fetch_line(fl_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(3), .PREFETCH(4)
    ) u_b (
        .clk50(clk), .rst(rst), .en(en_b), .pix_ce(pce_b), .hsync_out(hs_b), .vsync_out(vs_b),
        .blank_out(bl_b), .x_out(x_b), .y_out(y_b), .newline_out(nl_b), .frame_out(fr_b),
        .vblank_irq(vb_b), .fetch_req(fq_b), .fetch_line(fl_b)
    );

    vga_timing_gen #(.H_POL(1), .V_POL(1)) u_c (
        .clk50(clk), .rst(rst), .en(en_c), .pix_ce(pce_c), .hsync_out(hs_c), .vsync_out(vs_c),
        .blank_out(bl_c), .x_out(x_c), .y_out(y_c), .newline_out(nl_c), .frame_out(fr_c),
        .vblank_irq(vb_c), .fetch_req(fq_c), .fetch_line(fl_c)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(0), .PIX_DIV(2), .PREFETCH(5)
    ) u_d (
        .clk50(clk), .rst(rst), .en(en_d), .pix_ce(pce_d), .hsync_out(hs_d), .vsync_out(vs_d),
        .blank_out(bl_d), .x_out(x_d), .y_out(y_d), .newline_out(nl_d), .frame_out(fr_d),
        .vblank_irq(vb_d), .fetch_req(fq_d), .fetch_line(fl_d)
    );

    // Reference: after n consecutive enabled edges, floor(n/div) pixel ticks have happened,
    // and the outputs describe pixel number ticks-1 in raster order.
    function automatic obs_t model(cfg_t c, int cyc);
        obs_t o;
        int ht, vt, t, p, h, v, nx;
        ht    = c.hvis + c.hfp + c.hsw + c.hbp;
        vt    = c.vvis + c.vfp + c.vsw + c.vbp;
        o     = '0;
        o.hsy = (c.hpol == 0);
        o.vsy = (c.vpol == 0);
        o.bl  = 1'b1;
        t     = cyc / c.div;
        if (t > 0) begin
            p     = t - 1;
            h     = p % ht;
            v     = (p / ht) % vt;
            nx    = (v == vt - 1) ? 0 : v + 1;
            o.pce = ((cyc % c.div) == 0);
            o.hsy = ((h >= c.hvis + c.hfp) && (h < c.hvis + c.hfp + c.hsw)) ? (c.hpol != 0) : (c.hpol == 0);
            o.vsy = ((v >= c.vvis + c.vfp) && (v < c.vvis + c.vfp + c.vsw)) ? (c.vpol != 0) : (c.vpol == 0);
            o.bl  = (h >= c.hvis) || (v >= c.vvis);
            o.nl  = (h == 0);
            o.fr  = (h == 0) && (v == 0);
            o.vb  = (h == 0) && (v == c.vvis);
            o.fq  = (h == ht - c.pf) && (nx < c.vvis);
            o.fl  = o.fq ? 16'(nx) : 16'd0;
            o.x   = 16'(h);
            o.y   = 16'(v);
        end
        return o;
    endfunction

    function automatic obs_t vec_obs(vec_t e);
        obs_t o;
        o.pce = e.pce; o.hsy = e.hsy; o.vsy = e.vsy; o.bl = e.bl;
        o.nl  = e.nl;  o.fr  = e.fr;  o.vb  = e.vb;  o.fq = e.fq;
        o.x   = 16'(e.x); o.y = 16'(e.y); o.fl = 16'(e.fl);
        return o;
    endfunction

    task automatic chk(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    task automatic check_models();
        chk("a_model", o_a, model(cfg[0], n[0]));
        chk("b_model", o_b, model(cfg[1], n[1]));
        chk("c_model", o_c, model(cfg[2], n[2]));
        chk("d_model", o_d, model(cfg[3], n[3]));
    endtask

    // One clock: advance the per-DUT enabled-edge counts, then check all outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        n[0] = (!rst || !en_a) ? 0 : n[0] + 1;
        n[1] = (!rst || !en_b) ? 0 : n[1] + 1;
        n[2] = (!rst || !en_c) ? 0 : n[2] + 1;
        n[3] = (!rst || !en_d) ? 0 : n[3] + 1;
        #1;
        check_models();
    endtask

    initial begin
        int guard, lo_a, lo_c, xs_a, xs_c, cnt_b, cnt_d;
        cfg[0] = '{800, 56, 120, 64, 600, 37, 6, 23, 0, 0, 1, 16};
        cfg[1] = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 0, 3, 4};
        cfg[2] = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 1, 1, 16};
        cfg[3] = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 0, 2, 5};
        //          n    x   y  bl hs vs nl fr vb fq fl pce
        tbl[0]  = '{1,   0,  0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{3,   0,  0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
        tbl[2]  = '{5,   0,  0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        tbl[3]  = '{6,   1,  0, 0, 1, 1, 0, 0, 0, 0, 0, 1};
        tbl[4]  = '{27,  8,  0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{33,  10, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1};
        tbl[6]  = '{35,  10, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0};
        tbl[7]  = '{36,  11, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{39,  12, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        tbl[9]  = '{42,  13, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{45,  0,  1, 0, 1, 1, 1, 0, 0, 0, 0, 1};
        tbl[11] = '{75,  10, 1, 1, 0, 1, 0, 0, 0, 1, 2, 1};
        tbl[12] = '{117, 10, 2, 1, 0, 1, 0, 0, 0, 1, 3, 1};
        tbl[13] = '{159, 10, 3, 1, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[14] = '{171, 0,  4, 1, 1, 1, 1, 0, 1, 0, 0, 1};
        tbl[15] = '{222, 3,  5, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[16] = '{285, 10, 6, 1, 0, 1, 0, 0, 0, 1, 0, 1};
        tbl[17] = '{297, 0,  0, 0, 1, 1, 1, 1, 0, 0, 0, 1};

        rst = 1'b0;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1; en_d = 1'b1;
        for (int i = 0; i < 4; i++) n[i] = 0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;

        // Hand-computed vectors for the small configuration (PIX_DIV = 3, PREFETCH = 4)
        for (int i = 0; i < 18; i++) begin
            guard = 0;
            while (n[1] < tbl[i].n && guard < 400) begin
                step();
                guard++;
            end
            chk_int("b_tbl_reach", n[1], tbl[i].n);
            chk($sformatf("b_tbl_%0d", i), o_b, vec_obs(tbl[i]));
        end

        // Default timing: first hsync pulse starts at x = 856 and lasts 120 cycles
        lo_a = 0; lo_c = 0; xs_a = -1; xs_c = -1;
        while (n[0] < 1200) begin
            step();
            if (hs_a == 1'b0) begin
                if (lo_a == 0) xs_a = int'(x_a);
                lo_a++;
            end
            if (hs_c == 1'b1) begin
                if (lo_c == 0) xs_c = int'(x_c);
                lo_c++;
            end
        end
        chk_int("a_hsync_start_x", xs_a, 856);
        chk_int("a_hsync_len", lo_a, 120);
        chk_int("c_hsync_start_x", xs_c, 856);
        chk_int("c_hsync_len", lo_c, 120);

        // en dropped mid-frame: idle on the next edge, restart with a frame pulse
        en_b = 1'b0;
        step();
        chk_int("b_drop_blank", int'(bl_b), 1);
        chk_int("b_drop_pce", int'(pce_b), 0);
        chk_int("b_drop_x", int'(x_b), 0);
        for (int i = 0; i < 9; i++) step();
        en_b = 1'b1;
        step();
        step();
        chk_int("b_restart_early_frame", int'(fr_b), 0);
        step();
        chk_int("b_restart_frame", int'(fr_b), 1);
        chk_int("b_restart_xy", int'(x_b) + int'(y_b), 0);
        chk_int("b_restart_pce", int'(pce_b), 1);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) n[i] = 0;
        check_models();
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk_int("b_rst_release_frame", int'(fr_b), 1);
        for (int i = 0; i < 300; i++) step();

        // Randomised enable bursts on the small configurations
        cnt_b = 0; cnt_d = 0;
        for (int i = 0; i < 8000; i++) begin
            if (cnt_b == 0) begin
                en_b  = ~en_b;
                cnt_b = en_b ? int'($urandom_range(700, 20)) : int'($urandom_range(15, 1));
            end
            if (cnt_d == 0) begin
                en_d  = ~en_d;
                cnt_d = en_d ? int'($urandom_range(500, 10)) : int'($urandom_range(12, 1));
            end
            cnt_b--;
            cnt_d--;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
